// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and legality check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_funct3,
  input  logic        st_load,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane_wdata,
  output logic        st_err,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [15:0] sel_half;
  logic [7:0]  sel_byte;

  always_comb begin
    st_be         = 4'b0000;
    st_lane_wdata = '0;
    st_err        = 1'b0;
    unique case (st_funct3)
      LS_B, LS_BU: begin
        st_be         = 4'b0001 << st_off;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      LS_H, LS_HU: begin
        st_be         = st_off[1] ? 4'b1100 : 4'b0011;
        st_lane_wdata = {2{st_wdata[15:0]}};
        st_err        = st_off[0];
      end
      LS_W: begin
        st_be         = 4'b1111;
        st_lane_wdata = st_wdata;
        st_err        = |st_off;
      end
      default: st_err = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (!st_load && (st_funct3 == LS_BU || st_funct3 == LS_HU)) begin
      st_err = 1'b1;
    end
  end

  always_comb begin
    sel_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    sel_byte = ld_off[0] ? sel_half[15:8] : sel_half[7:0];
    ld_data  = '0;
    unique case (ld_funct3)
      LS_B:    ld_data = {{24{sel_byte[7]}}, sel_byte};
      LS_BU:   ld_data = {24'h0, sel_byte};
      LS_H:    ld_data = {{16{sel_half[15]}}, sel_half};
      LS_HU:   ld_data = {16'h0, sel_half};
      LS_W:    ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage over a valid/grant/rvalid word bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic              err_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_lane_wdata;
  logic              st_err;
  logic [DATA_W-1:0] ld_data;

  // Store steering and legality act on the live request; extraction on the latched access.
  lsu_align u_align (
    .st_off        (req_addr[1:0]),
    .st_funct3     (req_funct3),
    .st_load       (req_load),
    .st_wdata      (req_wdata),
    .st_be         (st_be),
    .st_lane_wdata (st_lane_wdata),
    .st_err        (st_err),
    .ld_off        (addr_q[1:0]),
    .ld_funct3     (funct3_q),
    .ld_rdata      (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = st_err ? StResp : StReq;
      StReq:   if (mem_gnt) state_d = we_q ? StResp : StWait;
      StWait:  if (mem_rvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        we_q     <= ~req_load;
        err_q    <= st_err;
        be_q     <= st_be;
        wdata_q  <= req_load ? '0 : st_lane_wdata;
        rdata_q  <= '0;
      end
      if (state_q == StWait && mem_rvalid) begin
        rdata_q <= ld_data;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_err   = (state_q == StResp) && err_q;
    rsp_rdata = (state_q == StResp) ? rdata_q : '0;
    mem_req   = (state_q == StReq);
    mem_we    = mem_req && we_q;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_wdata = mem_req ? wdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit checked cycle-by-cycle against an arithmetic model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Expected outputs for the current cycle, maintained by the driver.
  bit          chk_en = 1'b0;
  logic        e_ready, e_rsp_valid, e_rsp_err, e_mem_req, e_mem_we;
  logic [31:0] e_rsp_rdata, e_mem_addr, e_mem_wdata;
  logic [3:0]  e_mem_be;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---- behavioural model ----
  function automatic int m_size(input logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic bit m_err(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (f3 >= 4 && !ld) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = (1 << m_size(f3)) - 1;
    return 4'((n << (a % 4)) & 15);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] v;
    int bits;
    bits = 8 * m_size(f3);
    if (bits == 32) return rd;
    v = (rd >> (8 * (a % 4))) & ((32'd1 << bits) - 1);
    if (f3 < 4 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
    return v;
  endfunction

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp_valid);
      if (e_rsp_valid) begin
        check("rsp_err", rsp_err, e_rsp_err);
        check("rsp_rdata", rsp_rdata, e_rsp_rdata);
      end
      check("mem_req", mem_req, e_mem_req);
      if (e_mem_req) begin
        check("mem_we", mem_we, e_mem_we);
        check("mem_addr", mem_addr, e_mem_addr);
        check("mem_be", mem_be, e_mem_be);
        check("mem_wdata", mem_wdata, e_mem_wdata);
      end
    end
  end

  task automatic idle_exp();
    e_ready = 1; e_rsp_valid = 0; e_rsp_err = 0; e_rsp_rdata = 0;
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_be = 0; e_mem_wdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and accept it; leaves the DUT in the state after acceptance.
  task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid = 1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 0; req_load = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    idle_exp();
    e_ready = 0;
  endtask

  task automatic txn(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int gd,
                     input int rdly, input int gap);
    issue(ld, f3, a, wd);
    if (m_err(ld, f3, a)) begin
      e_rsp_valid = 1; e_rsp_err = 1; e_rsp_rdata = 0;
      step();
    end else begin
      e_mem_req = 1; e_mem_we = !ld; e_mem_addr = a & ~32'h3; e_mem_be = m_be(f3, a);
      e_mem_wdata = ld ? 32'h0 : m_wdata(f3, wd);
      for (int i = 0; i < gd; i++) begin
        mem_gnt = 0; mem_rvalid = $urandom_range(0, 1); mem_rdata = $urandom;
        step();
      end
      mem_gnt = 1; mem_rvalid = 0;
      step();
      mem_gnt = 0;
      e_mem_req = 0;
      if (ld) begin
        for (int i = 0; i < rdly; i++) begin
          mem_rvalid = 0; mem_rdata = $urandom;
          step();
        end
        mem_rvalid = 1; mem_rdata = rd;
        step();
        mem_rvalid = 0;
        e_rsp_rdata = m_load(rd, a, f3);
      end else begin
        e_rsp_rdata = 0;
      end
      e_rsp_valid = 1; e_rsp_err = 0;
      step();
    end
    idle_exp();
    // Stray rvalid while idle must be ignored.
    for (int i = 0; i < gap; i++) begin
      mem_rvalid = $urandom_range(0, 1); mem_rdata = $urandom;
      step();
    end
    mem_rvalid = 0;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_load = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    // Model pins against hand-computed values.
    check("pin_lb", m_load(32'h80FF1234, 32'h1003, 3'b000), 32'hFFFFFF80);
    check("pin_lbu", m_load(32'h80FF1234, 32'h1003, 3'b100), 32'h00000080);
    check("pin_lh", m_load(32'h80FF1234, 32'h1002, 3'b001), 32'hFFFF80FF);
    check("pin_be_b", m_be(3'b000, 32'h1003), 4'b1000);
    check("pin_be_h", m_be(3'b001, 32'h2002), 4'b1100);
    check("pin_wd_h", m_wdata(3'b001, 32'h1234BEEF), 32'hBEEFBEEF);
    check("pin_err_w", m_err(1'b1, 3'b010, 32'h3002), 1'b1);
    check("pin_err_su", m_err(1'b0, 3'b100, 32'h0), 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_be", mem_be, 4'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    idle_exp();
    chk_en = 1;
    step();

    // Directed cases.
    txn(1, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 1);
    txn(1, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 0, 0);
    txn(1, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 1, 2, 0);
    txn(0, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 0, 0, 0);
    txn(1, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 0);
    txn(0, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 5, 0, 2);

    // Reset while waiting for load data: late rvalid must not produce a response.
    issue(1, 3'b010, 32'h4000, 32'h0);
    e_mem_req = 1; e_mem_we = 0; e_mem_addr = 32'h4000; e_mem_be = 4'hF; e_mem_wdata = 0;
    mem_gnt = 1;
    step();
    mem_gnt = 0; e_mem_req = 0; rst = 1;
    step();
    rst = 0; idle_exp(); mem_rvalid = 1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 0;
    step();
    txn(1, 3'b101, 32'h4006, 32'h0, 32'hA5C3_0000, 0, 1, 0);

    // Reset while requesting: mem_req must drop on the next edge.
    issue(0, 3'b000, 32'h5001, 32'h77);
    e_mem_req = 1; e_mem_we = 1; e_mem_addr = 32'h5000; e_mem_be = 4'b0010;
    e_mem_wdata = 32'h77777777; rst = 1;
    step();
    rst = 0; idle_exp();
    step();

    for (int n = 0; n < 200; n++) begin
      int gd;
      gd = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
      txn(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, $urandom, gd,
          $urandom_range(0, 3), $urandom_range(0, 2));
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
